mem_axi_bridge: RTL and testbench

- Sits directly downstream of the mem stage and consumes its simple bus request (request_enable/mode/addr/wdata/wstrb).
- Performs exactly one AXI4-Lite master transaction per request.
- Returns a single-cycle response_enable pulse, plus read data, to the mem stage.
- Latches AXI error responses in a sticky flag for the trap/debug logic.

---
 rtl/mem_axi_bridge.sv | 162 ++++++++++++++++
 tb/tb_mem_axi_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge: turns one mem-stage bus request into exactly one AXI4-Lite read or write.
// Latency: acceptance edge N -> response_enable high in cycle N+3 with zero-wait slaves.
// Backpressure: AXI valids held until ready; new requests ignored until IDLE and re-armed.
module mem_axi_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rstn,
    // mem-stage request / response
    input  logic                request_enable,
    input  logic                mode,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic                response_enable,
    output logic [DATA_W-1:0]   data,
    output logic                bus_error,
    // AXI4-Lite write address / data / response
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    // AXI4-Lite read address / data
    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready
);

    localparam logic       MEMREQ_WRITE = 1'b1;
    localparam logic [1:0] RESP_OKAY    = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                armed;
    logic                aw_done;
    logic                w_done;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W/8-1:0] req_wstrb;

    logic accept;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;

    // Handshakes and AXI controls are pure functions of state, so reset clears them at once.
    assign accept          = (state == IDLE) && request_enable && armed;
    assign m_awvalid       = (state == WR) && !aw_done;
    assign m_wvalid        = (state == WR) && !w_done;
    assign m_bready        = (state == WR_RESP);
    assign m_arvalid       = (state == RD_ADDR);
    assign m_rready        = (state == RD_DATA);
    assign response_enable = (state == DONE);
    assign m_awaddr        = req_addr;
    assign m_araddr        = req_addr;
    assign m_wdata         = req_wdata;
    assign m_wstrb         = req_wstrb;

    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid  && m_wready;
    assign b_hs  = m_bvalid  && m_bready;
    assign ar_hs = m_arvalid && m_arready;
    assign r_hs  = m_rvalid  && m_rready;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one transaction per accepted request, AW and W may complete in any order.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (mode == MEMREQ_WRITE) ? WR : RD_ADDR;
            WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
            WR_RESP: if (b_hs) state_nxt = DONE;
            RD_ADDR: if (ar_hs) state_nxt = RD_DATA;
            RD_DATA: if (r_hs) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Arming: a level request is taken once and only re-armed after the line drops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            armed <= 1'b1;
        end else if (!request_enable) begin
            armed <= 1'b1;
        end else if (accept) begin
            armed <= 1'b0;
        end
    end

    // Capture request payload at acceptance; later input changes are ignored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_addr  <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
        end else if (accept) begin
            req_addr  <= addr;
            req_wdata <= wdata;
            req_wstrb <= wstrb;
        end
    end

    // Track AW and W completion independently while in WR; cleared in every other state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state != WR) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end

    // Response data and sticky error; read data is kept even when RRESP reports an error.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data      <= '0;
            bus_error <= 1'b0;
        end else if (b_hs) begin
            data <= '0;
            if (m_bresp != RESP_OKAY) bus_error <= 1'b1;
        end else if (r_hs) begin
            data <= m_rdata;
            if (m_rresp != RESP_OKAY) bus_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_axi_bridge.sv
// tb_mem_axi_bridge: randomized AXI4-Lite slave plus transaction-level reference model.
// Latency: expected response time is derived from slave wait-state settings.
// Backpressure: slave delays each ready/valid by a configurable number of cycles.
module tb_mem_axi_bridge;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        request_enable = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        response_enable;
    logic [31:0] data;
    logic        bus_error;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready = 1'b0;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready = 1'b0;
    logic [1:0]  m_bresp = 2'b00;
    logic        m_bvalid = 1'b0;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = 2'b00;
    logic        m_rvalid = 1'b0;
    logic        m_rready;

    mem_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .request_enable(request_enable), .mode(mode), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .response_enable(response_enable), .data(data), .bus_error(bus_error),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    // Slave configuration (wait states and response contents).
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  bresp_v = 2'b00;
    logic [1:0]  rresp_v = 2'b00;
    logic [31:0] rdata_v = '0;

    // Slave / monitor state.
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_resp = 0;
    int          aw_hi = 0, w_hi = 0, proto_err = 0;
    logic        aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    logic        aw_pend = 0, w_pend = 0, ar_pend = 0;
    logic [31:0] awaddr_q, wdata_q, araddr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] last_awaddr, last_wdata, last_araddr, last_data;
    logic [3:0]  last_wstrb;
    logic        last_berr;

    // Reactive slave: decide ready/valid at each falling edge, so a handshake flagged
    // here takes effect at the next rising edge and is counted at the following fall.
    always @(negedge clk) begin
        if (!rstn) begin
            m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
            m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
            aw_pend = 0; w_pend = 0; ar_pend = 0;
            n_b = (n_aw < n_w) ? n_aw : n_w;
            n_r = n_ar;
        end else begin
            // A valid still waiting for ready must stay up with an unchanged payload.
            if (aw_pend && (!m_awvalid || m_awaddr !== awaddr_q)) proto_err++;
            if (w_pend && (!m_wvalid || m_wdata !== wdata_q || m_wstrb !== wstrb_q)) proto_err++;
            if (ar_pend && (!m_arvalid || m_araddr !== araddr_q)) proto_err++;
            if (aw_hs) n_aw++;
            if (w_hs)  n_w++;
            if (ar_hs) n_ar++;
            if (b_hs) begin n_b++; m_bvalid = 0; end
            if (r_hs) begin n_r++; m_rvalid = 0; end
            // B only after both AW and W of a write have been accepted.
            if (!m_bvalid && ((n_aw < n_w) ? n_aw : n_w) > n_b) begin
                if (b_wait >= b_dly) begin m_bvalid = 1; m_bresp = bresp_v; b_wait = 0; end
                else b_wait++;
            end
            if (!m_bvalid) m_bresp = 2'b11;
            if (!m_rvalid && n_ar > n_r) begin
                if (r_wait >= r_dly) begin m_rvalid = 1; m_rdata = rdata_v; m_rresp = rresp_v; r_wait = 0; end
                else r_wait++;
            end
            if (!m_rvalid) begin m_rdata = ~rdata_v; m_rresp = 2'b11; end
            if (m_awvalid) begin
                aw_hi++;
                m_awready = (aw_wait >= aw_dly);
                if (!m_awready) aw_wait++;
            end else begin m_awready = 0; aw_wait = 0; end
            if (m_wvalid) begin
                w_hi++;
                m_wready = (w_wait >= w_dly);
                if (!m_wready) w_wait++;
            end else begin m_wready = 0; w_wait = 0; end
            if (m_arvalid) begin
                m_arready = (ar_wait >= ar_dly);
                if (!m_arready) ar_wait++;
            end else begin m_arready = 0; ar_wait = 0; end
            aw_hs = m_awvalid && m_awready;
            w_hs  = m_wvalid && m_wready;
            ar_hs = m_arvalid && m_arready;
            b_hs  = m_bvalid && m_bready;
            r_hs  = m_rvalid && m_rready;
            if (aw_hs) last_awaddr = m_awaddr;
            if (w_hs) begin last_wdata = m_wdata; last_wstrb = m_wstrb; end
            if (ar_hs) last_araddr = m_araddr;
            aw_pend = m_awvalid && !aw_hs; awaddr_q = m_awaddr;
            w_pend  = m_wvalid && !w_hs;   wdata_q = m_wdata; wstrb_q = m_wstrb;
            ar_pend = m_arvalid && !ar_hs; araddr_q = m_araddr;
            if (response_enable) begin n_resp++; last_data = data; last_berr = bus_error; end
        end
    end

    int          checks = 0;
    int          errors = 0;
    logic        exp_berr = 1'b0;
    logic [31:0] exp_data = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_slave(input int aw, input int w, input int b, input int ar, input int r);
        aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    // One request through the bridge, checked against the transaction-level model.
    task automatic do_req(input logic md, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input int hold);
        int s_aw, s_w, s_b, s_ar, s_r, s_resp, s_awhi, s_whi, lat, exp_lat;
        chk("data_hold", 64'(data), 64'(exp_data));
        s_aw = n_aw; s_w = n_w; s_b = n_b; s_ar = n_ar; s_r = n_r; s_resp = n_resp;
        s_awhi = aw_hi; s_whi = w_hi;
        exp_lat = md ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
        request_enable = 1; mode = md; addr = a; wdata = wd; wstrb = ws;
        lat = 0;
        while (n_resp == s_resp && lat < 100) begin
            @(negedge clk); #1;
            lat++;
            if (lat == 1) begin
                mode = ~md; addr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
            end
        end
        chk("resp_latency", 64'(lat), 64'(exp_lat));
        exp_berr = exp_berr | (md ? (bresp_v != 2'b00) : (rresp_v != 2'b00));
        exp_data = md ? 32'h0 : rdata_v;
        chk("resp_data", 64'(last_data), 64'(exp_data));
        chk("resp_berr", 64'(last_berr), 64'(exp_berr));
        for (int i = 0; i < hold + 2; i++) begin
            @(negedge clk); #1;
            if (i == 0) chk("single_pulse", 64'(response_enable), 64'(0));
        end
        chk("resp_count", 64'(n_resp - s_resp), 64'(1));
        if (md) begin
            chk("aw_count", 64'(n_aw - s_aw), 64'(1));
            chk("w_count", 64'(n_w - s_w), 64'(1));
            chk("b_count", 64'(n_b - s_b), 64'(1));
            chk("ar_none", 64'(n_ar - s_ar), 64'(0));
            chk("awaddr", 64'(last_awaddr), 64'(a));
            chk("wdata_wstrb", {28'h0, last_wstrb, last_wdata}, {28'h0, ws, wd});
            chk("awvalid_cycles", 64'(aw_hi - s_awhi), 64'(aw_dly + 1));
            chk("wvalid_cycles", 64'(w_hi - s_whi), 64'(w_dly + 1));
        end else begin
            chk("ar_count", 64'(n_ar - s_ar), 64'(1));
            chk("r_count", 64'(n_r - s_r), 64'(1));
            chk("aw_w_none", 64'((n_aw - s_aw) + (n_w - s_w)), 64'(0));
            chk("araddr", 64'(last_araddr), 64'(a));
        end
        chk("bus_error", 64'(bus_error), 64'(exp_berr));
        chk("protocol", 64'(proto_err), 64'(0));
        request_enable = 0;
        @(negedge clk); #1;
    endtask

    initial begin
        int lat, s_resp;
        set_slave(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctrl", 64'({response_enable, bus_error, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 64'(0));
        chk("reset_data", 64'(data), 64'(0));
        chk("reset_addr", {m_awaddr, m_araddr}, 64'(0));
        rstn = 1;
        @(negedge clk); #1;

        // Zero-wait read.
        rdata_v = 32'hDEADBEEF;
        do_req(1'b0, 32'h1000, 32'h0, 4'h0, 0);
        // Write with AW ready late, W immediate.
        set_slave(3, 0, 0, 0, 0);
        do_req(1'b1, 32'h2004, 32'h12345678, 4'b0011, 0);
        // W before AW, then both in the same cycle.
        set_slave(2, 0, 1, 0, 0);
        do_req(1'b1, 32'h2008, 32'hCAFEF00D, 4'b1111, 0);
        set_slave(2, 2, 0, 0, 0);
        do_req(1'b1, 32'h200C, 32'hA5A5A5A5, 4'b0101, 0);
        // Request held high long after its response, then re-issued after one low cycle.
        set_slave(0, 0, 0, 0, 0);
        rdata_v = 32'h01234567;
        do_req(1'b0, 32'h4000, 32'h0, 4'h0, 20);
        rdata_v = 32'h89ABCDEF;
        do_req(1'b0, 32'h4004, 32'h0, 4'h0, 0);
        // Error read response is sticky across a following OKAY write.
        rresp_v = 2'b10; rdata_v = 32'h55;
        do_req(1'b0, 32'h5000, 32'h0, 4'h0, 0);
        rresp_v = 2'b00;
        do_req(1'b1, 32'h5004, 32'h77, 4'b0001, 0);

        // Reset while waiting for read data.
        set_slave(0, 0, 0, 0, 8);
        request_enable = 1; mode = 0; addr = 32'h3000;
        lat = 0;
        while (!m_rready && lat < 20) begin @(negedge clk); #1; lat++; end
        chk("reach_rd_data", 64'(m_rready), 64'(1));
        s_resp = n_resp;
        #1 rstn = 0;
        #1;
        chk("rst_ctrl", 64'({response_enable, bus_error, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 64'(0));
        chk("rst_data", 64'(data), 64'(0));
        chk("rst_addr", {m_awaddr, m_araddr}, 64'(0));
        request_enable = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_no_resp", 64'(n_resp - s_resp), 64'(0));
        rstn = 1;
        exp_berr = 0; exp_data = '0;
        @(negedge clk); #1;
        set_slave(0, 0, 0, 0, 0);
        rdata_v = 32'h600DF00D;
        do_req(1'b0, 32'h3000, 32'h0, 4'h0, 0);

        // Randomized traffic with random wait states and occasional error responses.
        for (int i = 0; i < 30; i++) begin
            set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            bresp_v = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rresp_v = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rdata_v = $urandom;
            do_req(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound on simulation time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
